// File: rtl/array_drain_pkg.sv
// Shared types for the systolic-array output drain: FSM state, latency helper, row record.
package array_drain_pkg;

  localparam int ARR_HEIGHT    = 4;
  localparam int ARR_WIDTH     = 4;
  localparam int ARR_OUT_WIDTH = 16;
  localparam int IDX_W         = (ARR_HEIGHT > 1) ? $clog2(ARR_HEIGHT) : 1;

  typedef enum logic {IDLE, DRAIN} drain_state_e;

  typedef struct packed {
    logic [ARR_WIDTH-1:0][ARR_OUT_WIDTH-1:0] data;
    logic [IDX_W-1:0]                        idx;
  } row_rec_t;

  // Last drain count: every column shifted, skewed and through the output latency.
  function automatic int drain_last(input int width, input int height, input int ofm_lat);
    return width + height + ofm_lat - 1;
  endfunction

endpackage

// File: rtl/drain_fifo.sv
// Synchronous FIFO of deskewed result rows; head holds the last popped row when empty.
module drain_fifo
  import array_drain_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int FW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  row_rec_t      push_rec,
  input  logic          pop,
  output row_rec_t      head_rec,
  output logic          head_valid,
  output logic [FW-1:0] free
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  row_rec_t      mem [DEPTH];
  row_rec_t      last_q;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0] count;
  logic          do_push, do_pop;

  function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign head_valid = (count != '0);
  assign do_pop     = pop && head_valid;
  assign do_push    = push && ((count != FW'(DEPTH)) || do_pop);
  assign head_rec   = head_valid ? mem[rd_ptr] : last_q;
  assign free       = FW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop) begin
        rd_ptr <= nxt(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_rec;
  end

  // Admission control upstream must make a dropped push impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && !do_push));

endmodule

// File: rtl/array_ofm_drain.sv
// Output-chain drain: column-skewed en/clr, deskew of row-0 outputs, row FIFO to writeback.
// Optional saturation of results and sat_flag port under `ARRAY_DRAIN_SAT_EN.
module array_ofm_drain
  import array_drain_pkg::*;
#(
  parameter int HEIGHT     = ARR_HEIGHT,
  parameter int WIDTH      = ARR_WIDTH,
  parameter int OWIDTH     = 24,
  parameter int OUT_WIDTH  = ARR_OUT_WIDTH,
  parameter int OFM_LAT    = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        start_ready,
  output logic [WIDTH-1:0]            en_o,
  output logic [WIDTH-1:0]            clr_o,
  input  logic signed [OWIDTH-1:0]    ofm [WIDTH],
  output logic signed [OUT_WIDTH-1:0] row_data [WIDTH],
  output logic [IDX_W-1:0]            row_idx,
  output logic                        row_valid,
  input  logic                        row_ready,
  output logic                        busy,
`ifdef ARRAY_DRAIN_SAT_EN
  output logic                        sat_flag,
`endif
  output logic                        done
);

  localparam int LAST       = drain_last(WIDTH, HEIGHT, OFM_LAT);
  localparam int CNT_W      = $clog2(LAST + 1);
  localparam int FIRST_PUSH = WIDTH - 1 + OFM_LAT;
  localparam int FW         = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < HEIGHT) begin : g_depth_chk
    $error("FIFO_DEPTH must be >= HEIGHT");
  end
  if (HEIGHT != ARR_HEIGHT || WIDTH != ARR_WIDTH || OUT_WIDTH != ARR_OUT_WIDTH) begin : g_rec_chk
    $error("row record geometry in array_drain_pkg does not match parameters");
  end

  drain_state_e      state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  en_d, clr_d;
  logic              done_d, accept, push;
  logic [FW-1:0]     free;
  row_rec_t          push_rec, head_rec;
  logic signed [OWIDTH-1:0] tap [WIDTH];

  // Column w is WIDTH-1-w cycles early relative to the last column; delay it to line up.
  for (genvar w = 0; w < WIDTH; w++) begin : g_col
    localparam int D = WIDTH - 1 - w;
    if (D == 0) begin : g_nodly
      assign tap[w] = ofm[w];
    end else begin : g_dly
      logic signed [OWIDTH-1:0] dl [D];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) dl[k] <= '0;
        end else begin
          dl[0] <= ofm[w];
          for (int k = 1; k < D; k++) dl[k] <= dl[k-1];
        end
      end
      assign tap[w] = dl[D-1];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: if (start && start_ready) begin
        state_d = DRAIN;
        cnt_d   = '0;
        accept  = 1'b1;
      end
      DRAIN: if (cnt_q == CNT_W'(LAST)) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    en_d  = '0;
    clr_d = '0;
    if (state_d == DRAIN) begin
      for (int w = 0; w < WIDTH; w++) begin
        en_d[w]  = (cnt_d >= CNT_W'(w)) && (cnt_d < CNT_W'(w + HEIGHT));
        clr_d[w] = (cnt_d == CNT_W'(w + HEIGHT));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      en_o    <= '0;
      clr_o   <= '0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_o    <= en_d;
      clr_o   <= clr_d;
      done    <= done_d;
    end
  end

  assign busy        = (state_q == DRAIN);
  assign start_ready = (state_q == IDLE) && (free >= FW'(HEIGHT));
  assign push        = (state_q == DRAIN) && (cnt_q >= CNT_W'(FIRST_PUSH))
                       && (cnt_q < CNT_W'(FIRST_PUSH + HEIGHT));

`ifdef ARRAY_DRAIN_SAT_EN
  localparam logic [OUT_WIDTH-1:0] SAT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] SAT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  logic [WIDTH-1:0] clip;

  always_comb begin
    push_rec = '0;
    clip     = '0;
    for (int w = 0; w < WIDTH; w++) begin
      push_rec.data[w] = tap[w][OUT_WIDTH-1:0];
      // Fits only if all bits above the result sign agree with it.
      if (!(&tap[w][OWIDTH-1:OUT_WIDTH-1]) && (|tap[w][OWIDTH-1:OUT_WIDTH-1])) begin
        clip[w]          = 1'b1;
        push_rec.data[w] = tap[w][OWIDTH-1] ? SAT_MIN : SAT_MAX;
      end
    end
    push_rec.idx = IDX_W'(cnt_q - CNT_W'(FIRST_PUSH));
  end

  always_ff @(posedge clk) begin
    if (rst)                sat_flag <= 1'b0;
    else if (accept)        sat_flag <= 1'b0;
    else if (push && |clip) sat_flag <= 1'b1;
  end
`else
  logic unused_hi;

  always_comb begin
    push_rec  = '0;
    unused_hi = 1'b0;
    for (int w = 0; w < WIDTH; w++) begin
      push_rec.data[w] = tap[w][OUT_WIDTH-1:0];
      unused_hi        = unused_hi ^ (^tap[w][OWIDTH-1:OUT_WIDTH]);
    end
    push_rec.idx = IDX_W'(cnt_q - CNT_W'(FIRST_PUSH));
  end
`endif

  drain_fifo #(.DEPTH(FIFO_DEPTH), .FW(FW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_rec   (push_rec),
    .pop        (row_ready),
    .head_rec   (head_rec),
    .head_valid (row_valid),
    .free       (free)
  );

  assign row_idx = head_rec.idx;
  always_comb begin
    for (int w = 0; w < WIDTH; w++) row_data[w] = head_rec.data[w];
  end

endmodule

// File: tb/tb_array_ofm_drain.sv
// Directed bench for array_ofm_drain with a behavioural array column model.
module tb_array_ofm_drain;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              start_ready;
  logic [3:0]        en_o, clr_o;
  logic signed [23:0] ofm [4];
  logic signed [15:0] row_data [4];
  logic [1:0]        row_idx;
  logic              row_valid;
  logic              row_ready = 1'b0;
  logic              busy, done;
`ifdef ARRAY_DRAIN_SAT_EN
  logic              sat_flag;
`endif

  int checks = 0;
  int errors = 0;
  logic [23:0] vals [4][4];
  int pc [4];

  always #5 clk = ~clk;

  array_ofm_drain dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .start_ready (start_ready),
    .en_o        (en_o),
    .clr_o       (clr_o),
    .ofm         (ofm),
    .row_data    (row_data),
    .row_idx     (row_idx),
    .row_valid   (row_valid),
    .row_ready   (row_ready),
    .busy        (busy),
`ifdef ARRAY_DRAIN_SAT_EN
    .sat_flag    (sat_flag),
`endif
    .done        (done)
  );

  // Array column model: each en_o pulse shifts out the next PE row one cycle later.
  always @(posedge clk) begin
    for (int w = 0; w < 4; w++) begin
      if (rst) begin
        pc[w]  <= 0;
        ofm[w] <= '0;
      end else begin
        if (en_o[w] && pc[w] < 4) begin
          ofm[w] <= vals[w][pc[w]];
          pc[w]  <= pc[w] + 1;
        end
        if (clr_o[w]) pc[w] <= 0;
      end
    end
  end

  task automatic set_default_vals();
    for (int w = 0; w < 4; w++)
      for (int j = 0; j < 4; j++) vals[w][j] = 24'(100 * w + j);
  endtask

  task automatic pulse_start_wait(output bit ok);
    ok = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (en_o !== 4'b0 || clr_o !== 4'b0) begin errors++; $display("FAIL reset_en_clr got %b/%b exp 0000/0000", en_o, clr_o); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b/%b exp 0/0", busy, done); end
    checks++; if (row_valid !== 1'b0 || row_idx !== 2'd0) begin errors++; $display("FAIL reset_row got v=%b idx=%0d exp 0/0", row_valid, row_idx); end
    for (int w = 0; w < 4; w++) begin
      checks++; if (row_data[w] !== 16'sd0) begin errors++; $display("FAIL reset_row_data[%0d] got %h exp 0000", w, row_data[w]); end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL reset_start_ready got %b exp 1", start_ready); end
  endtask

  task automatic test_basic();
    int k;
    logic [3:0] exp_en, exp_clr;
    k = 0;
    row_ready = 1'b1;
    start = 1'b1;
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL basic_start_ready got %b exp 1", start_ready); end
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 13; c++) begin
      for (int w = 0; w < 4; w++) begin
        exp_en[w]  = (c >= w && c < w + 4);
        exp_clr[w] = (c == w + 4);
      end
      checks++; if (en_o !== exp_en) begin errors++; $display("FAIL basic_en cnt=%0d got %b exp %b", c, en_o, exp_en); end
      checks++; if (clr_o !== exp_clr) begin errors++; $display("FAIL basic_clr cnt=%0d got %b exp %b", c, clr_o, exp_clr); end
      checks++; if (done !== (c == 9)) begin errors++; $display("FAIL basic_done cnt=%0d got %b", c, done); end
      checks++; if (busy !== (c <= 8)) begin errors++; $display("FAIL basic_busy cnt=%0d got %b", c, busy); end
      if (row_valid) begin
        checks++; if (row_idx !== 2'(k)) begin errors++; $display("FAIL basic_row_idx got %0d exp %0d", row_idx, k); end
        for (int w = 0; w < 4; w++) begin
          checks++; if (row_data[w] !== 16'(100 * w + k)) begin errors++; $display("FAIL basic_row%0d_col%0d got %0d exp %0d", k, w, row_data[w], 100 * w + k); end
        end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k != 4) begin errors++; $display("FAIL basic_row_count got %0d exp 4", k); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int k;
    row_ready = 1'b0;
    pulse_start_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain1_done got timeout exp done"); end
    checks++; if (row_valid !== 1'b1 || row_idx !== 2'd0 || row_data[1] !== 16'sd100) begin errors++; $display("FAIL bp_head_held got v=%b idx=%0d d1=%0d exp 1/0/100", row_valid, row_idx, row_data[1]); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_free4 got %b exp 1", start_ready); end
    pulse_start_wait(ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain2_done got timeout exp done"); end
    checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_free0 got %b exp 0", start_ready); end
    start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_start_ignored busy got %b exp 0", busy); end
    row_ready = 1'b1;
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (row_valid) begin
        checks++; if (row_idx !== 2'(k % 4) || row_data[2] !== 16'(200 + k % 4)) begin errors++; $display("FAIL bp_pop%0d got idx=%0d d2=%0d exp %0d/%0d", k, row_idx, row_data[2], k % 4, 200 + k % 4); end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k != 8) begin errors++; $display("FAIL bp_pop_count got %0d exp 8", k); end
    checks++; if (row_valid !== 1'b0 || row_data[3] !== 16'sd303) begin errors++; $display("FAIL bp_empty_hold got v=%b d3=%0d exp 0/303", row_valid, row_data[3]); end
    checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after got %b exp 1", start_ready); end
  endtask

  task automatic test_start_in_drain();
    int k, dn;
    k = 0; dn = 0;
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      start = (c >= 1 && c <= 5);
      if (done) dn++;
      if (row_valid) k++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (dn != 1) begin errors++; $display("FAIL sid_done_count got %0d exp 1", dn); end
    checks++; if (k != 4) begin errors++; $display("FAIL sid_row_count got %0d exp 4", k); end
  endtask

  task automatic test_rst_mid();
    int k, dn;
    row_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (en_o !== 4'b1111) begin errors++; $display("FAIL rst_pre_en got %b exp 1111", en_o); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (en_o !== 4'b0 || clr_o !== 4'b0) begin errors++; $display("FAIL rst_mid_en_clr got %b/%b exp 0000/0000", en_o, clr_o); end
    checks++; if (row_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_state got v=%b busy=%b done=%b exp 0/0/0", row_valid, busy, done); end
    dn = 0;
    repeat (12) begin
      if (done || busy) dn++;
      @(negedge clk);
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL rst_mid_no_done got %0d active cycles exp 0", dn); end
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0; dn = 0;
    for (int c = 0; c < 14; c++) begin
      if (done) dn++;
      if (row_valid) begin
        checks++; if (row_idx !== 2'(k) || row_data[0] !== 16'(k) || row_data[3] !== 16'(300 + k)) begin errors++; $display("FAIL rst_fresh_row%0d got idx=%0d d0=%0d d3=%0d", k, row_idx, row_data[0], row_data[3]); end
        k++;
      end
      @(negedge clk);
    end
    checks++; if (k != 4 || dn != 1) begin errors++; $display("FAIL rst_fresh_counts got rows=%0d done=%0d exp 4/1", k, dn); end
  endtask

  task automatic test_narrow();
    bit seen;
    seen = 1'b0;
    vals[0][0] = 24'h7FFFFF;
    vals[1][0] = 24'h800000;
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (row_valid && !seen) begin
        seen = 1'b1;
`ifdef ARRAY_DRAIN_SAT_EN
        checks++; if (row_data[0] !== 16'h7FFF || row_data[1] !== 16'h8000) begin errors++; $display("FAIL narrow_sat got %h/%h exp 7fff/8000", row_data[0], row_data[1]); end
`else
        checks++; if (row_data[0] !== 16'hFFFF || row_data[1] !== 16'h0000) begin errors++; $display("FAIL narrow_trunc got %h/%h exp ffff/0000", row_data[0], row_data[1]); end
`endif
        checks++; if (row_data[2] !== 16'sd200) begin errors++; $display("FAIL narrow_col2 got %0d exp 200", row_data[2]); end
      end
      @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL narrow_row_seen got none exp 1 row"); end
`ifdef ARRAY_DRAIN_SAT_EN
    checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL narrow_sat_flag got %b exp 1", sat_flag); end
`endif
    set_default_vals();
  endtask

  task automatic test_back_to_back();
    int k, dn;
    bit second;
    k = 0; dn = 0; second = 1'b0;
    row_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
`ifdef ARRAY_DRAIN_SAT_EN
    checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL b2b_sat_clear got %b exp 0", sat_flag); end
`endif
    for (int c = 0; c < 30; c++) begin
      start = 1'b0;
      if (row_valid) begin
        checks++; if (row_idx !== 2'(k % 4) || row_data[1] !== 16'(100 + k % 4)) begin errors++; $display("FAIL b2b_row%0d got idx=%0d d1=%0d exp %0d/%0d", k, row_idx, row_data[1], k % 4, 100 + k % 4); end
        k++;
      end
      if (done) begin
        dn++;
        if (!second) begin
          second = 1'b1;
          start = 1'b1;
          checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_at_done got %b exp 1", start_ready); end
          @(negedge clk);
          start = 1'b0;
          checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_second_accept busy got %b exp 1", busy); end
          continue;
        end
      end
      @(negedge clk);
    end
    checks++; if (k != 8 || dn != 2) begin errors++; $display("FAIL b2b_counts got rows=%0d done=%0d exp 8/2", k, dn); end
  endtask

  initial begin
    set_default_vals();
    test_reset();
    test_basic();
    test_backpressure();
    test_start_in_drain();
    test_rst_mid();
    test_narrow();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
